// File: rtl/elevador_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | elevador_pkg - button codes, direction encoding and floor/bit helpers |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package elevador_pkg;

  localparam int N_BOTONES = 10;

  localparam logic [3:0] COD_NADA       = 4'd0;
  localparam logic [3:0] COD_P1         = 4'd1;
  localparam logic [3:0] COD_P2         = 4'd2;
  localparam logic [3:0] COD_P3         = 4'd3;
  localparam logic [3:0] COD_P4         = 4'd4;
  localparam logic [3:0] COD_SUB_P1     = 4'd5;
  localparam logic [3:0] COD_BAJ_P2     = 4'd6;
  localparam logic [3:0] COD_SUB_P2     = 4'd7;
  localparam logic [3:0] COD_BAJ_P3     = 4'd8;
  localparam logic [3:0] COD_SUB_P3     = 4'd9;
  localparam logic [3:0] COD_BAJ_P4     = 4'd10;
  localparam logic [3:0] COD_MAX_VALIDO = COD_BAJ_P4;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Bit k-1 of the pending bitmap holds button code k.
  function automatic logic [3:0] bit_cabina(input logic [1:0] piso);
    return {2'b00, piso};
  endfunction

  function automatic logic [3:0] bit_subir(input logic [1:0] piso);
    return 4'd4 + {1'b0, piso, 1'b0};
  endfunction

  function automatic logic [3:0] bit_bajar(input logic [1:0] piso);
    return 4'd3 + {1'b0, piso, 1'b0};
  endfunction

  function automatic logic [3:0] pisos_ocupados(input logic [N_BOTONES-1:0] pend);
    return {pend[3] | pend[9],
            pend[2] | pend[7] | pend[8],
            pend[1] | pend[5] | pend[6],
            pend[0] | pend[4]};
  endfunction

  function automatic logic [3:0] mascara_arriba(input logic [1:0] piso);
    return 4'b1110 << piso;
  endfunction

  function automatic logic [3:0] mascara_abajo(input logic [1:0] piso);
    return ~(4'b1111 << piso);
  endfunction

endpackage
`default_nettype wire

// File: rtl/planificador_solicitudes_selector_destino.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | selector_destino - floor flags and next target code from a bitmap     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module selector_destino
  import elevador_pkg::*;
(
  input  logic [N_BOTONES-1:0] pendientes,
  input  logic [1:0]           piso,
  input  dir_e                 direccion,
  output logic                 arriba,
  output logic                 abajo,
  output logic                 aqui,
  output logic [3:0]           destino
);

  logic [3:0] ocupados;
  logic       atender_aqui;

  assign ocupados = pisos_ocupados(pendientes);
  assign arriba   = |(ocupados & mascara_arriba(piso));
  assign abajo    = |(ocupados & mascara_abajo(piso));
  assign aqui     = ocupados[piso];

  always_comb begin
    atender_aqui = pendientes[bit_cabina(piso)] || (direccion == DIR_IDLE);
    if (direccion == DIR_UP && piso != 2'd3) begin
      atender_aqui = atender_aqui || pendientes[bit_subir(piso)];
    end
    if (direccion == DIR_DOWN && piso != 2'd0) begin
      atender_aqui = atender_aqui || pendientes[bit_bajar(piso)];
    end
  end

  // Scan order makes the last hit the nearest floor in the sweep direction.
  always_comb begin
    destino = 4'd0;
    if (aqui && atender_aqui) begin
      destino = {2'b00, piso} + 4'd1;
    end else if (direccion == DIR_UP) begin
      for (int f = 3; f >= 0; f--) begin
        if (ocupados[f] && f > int'(piso)) destino = 4'(f + 1);
      end
    end else if (direccion == DIR_DOWN) begin
      for (int f = 0; f < 4; f++) begin
        if (ocupados[f] && f < int'(piso)) destino = 4'(f + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/planificador_solicitudes.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | planificador_solicitudes - SCAN request scheduler for 4-floor elevator|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module planificador_solicitudes
  import elevador_pkg::*;
#(
  parameter int N_PISOS        = 4,
  parameter bit DIR_PREF_SUBIR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       boton_valid,
  input  logic [3:0]                 boton_pres,
  input  logic                       obtener,
  input  logic [$clog2(N_PISOS)-1:0] piso,
  input  logic                       puertas,
  output logic [3:0]                 solicitud,
  output logic                       solicitud_valid,
  output logic [N_BOTONES-1:0]       pendientes,
  output logic [1:0]                 direccion,
  output logic                       error_codigo
);

  logic [N_BOTONES-1:0] pendientes_q, pendientes_d;
  dir_e                 direccion_q, direccion_d, dir_next;
  logic [3:0]           solicitud_q, solicitud_d;
  logic                 solicitud_valid_q, solicitud_valid_d;
  logic                 error_codigo_q, error_codigo_d;
  logic                 puertas_q, puertas_d;

  logic [N_BOTONES-1:0] bits_set, bits_clr, pend_set, pend_post;
  logic [3:0]           ocup_set;
  logic                 adelante_sub, adelante_baj, evento_puertas;
  logic                 codigo_invalido;
  logic                 arriba, abajo, aqui;
  logic [3:0]           destino;

  always_comb begin
    bits_set        = '0;
    codigo_invalido = 1'b0;
    if (en && boton_valid) begin
      if (boton_pres > COD_MAX_VALIDO) begin
        codigo_invalido = 1'b1;
      end else if (boton_pres != COD_NADA) begin
        bits_set = {{(N_BOTONES-1){1'b0}}, 1'b1} << (boton_pres - 4'd1);
      end
    end
  end

  assign pend_set       = pendientes_q | bits_set;
  assign ocup_set       = pisos_ocupados(pend_set);
  assign adelante_sub   = |(ocup_set & mascara_arriba(piso));
  assign adelante_baj   = |(ocup_set & mascara_abajo(piso));
  assign evento_puertas = en && puertas && !puertas_q;

  // Opposite hall call is served too once nothing remains ahead in the sweep.
  always_comb begin
    bits_clr = '0;
    if (evento_puertas) begin
      bits_clr[bit_cabina(piso)] = 1'b1;
      if (piso != 2'd3 && (direccion_q != DIR_DOWN || !adelante_baj)) begin
        bits_clr[bit_subir(piso)] = 1'b1;
      end
      if (piso != 2'd0 && (direccion_q != DIR_UP || !adelante_sub)) begin
        bits_clr[bit_bajar(piso)] = 1'b1;
      end
    end
  end

  assign pend_post = pend_set & ~bits_clr;

  selector_destino u_selector (
    .pendientes (pend_post),
    .piso       (piso),
    .direccion  (dir_next),
    .arriba     (arriba),
    .abajo      (abajo),
    .aqui       (aqui),
    .destino    (destino)
  );

  always_comb begin
    dir_next = direccion_q;
    case (direccion_q)
      DIR_IDLE: begin
        if (arriba && (!abajo || DIR_PREF_SUBIR)) begin
          dir_next = DIR_UP;
        end else if (abajo) begin
          dir_next = DIR_DOWN;
        end else if (aqui) begin
          dir_next = DIR_IDLE;
        end
      end
      DIR_UP:   if (!arriba) dir_next = abajo ? DIR_DOWN : DIR_IDLE;
      DIR_DOWN: if (!abajo)  dir_next = arriba ? DIR_UP : DIR_IDLE;
      default:  dir_next = DIR_IDLE;
    endcase
  end

  always_comb begin
    pendientes_d      = pendientes_q;
    direccion_d       = direccion_q;
    solicitud_d       = solicitud_q;
    solicitud_valid_d = solicitud_valid_q;
    error_codigo_d    = error_codigo_q;
    puertas_d         = puertas;
    if (en) begin
      pendientes_d      = pend_post;
      direccion_d       = dir_next;
      solicitud_valid_d = obtener;
      error_codigo_d    = codigo_invalido;
      if (obtener) solicitud_d = destino;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendientes_q      <= '0;
      direccion_q       <= DIR_IDLE;
      solicitud_q       <= 4'd0;
      solicitud_valid_q <= 1'b0;
      error_codigo_q    <= 1'b0;
      puertas_q         <= 1'b0;
    end else begin
      pendientes_q      <= pendientes_d;
      direccion_q       <= direccion_d;
      solicitud_q       <= solicitud_d;
      solicitud_valid_q <= solicitud_valid_d;
      error_codigo_q    <= error_codigo_d;
      puertas_q         <= puertas_d;
    end
  end

  assign pendientes      = pendientes_q;
  assign direccion       = direccion_q;
  assign solicitud       = solicitud_q;
  assign solicitud_valid = solicitud_valid_q;
  assign error_codigo    = error_codigo_q;

endmodule
`default_nettype wire

// File: tb/tb_planificador_solicitudes.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_planificador_solicitudes - vectors, corner sequences, random model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_planificador_solicitudes;

  logic       clk = 1'b0;
  logic       rst, en, boton_valid, obtener, puertas;
  logic [3:0] boton_pres, solicitud;
  logic [1:0] piso, direccion;
  logic [9:0] pendientes;
  logic       solicitud_valid, error_codigo;

  always #5 clk = ~clk;

  planificador_solicitudes #(.N_PISOS(4), .DIR_PREF_SUBIR(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .boton_valid(boton_valid),
    .boton_pres(boton_pres), .obtener(obtener), .piso(piso),
    .puertas(puertas), .solicitud(solicitud),
    .solicitud_valid(solicitud_valid), .pendientes(pendientes),
    .direccion(direccion), .error_codigo(error_codigo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference model: pending calls indexed by button code; floor/kind by arithmetic.
  bit m_pend[1:10];
  int m_dir, m_sol;
  bit m_valid, m_err, m_pq;

  function automatic int floor_of(input int c);
    return (c <= 4) ? c - 1 : c / 2 - 2;
  endfunction

  function automatic int kind_of(input int c); // 0 car, 1 hall-up, 2 hall-down
    return (c <= 4) ? 0 : ((c % 2 == 1) ? 1 : 2);
  endfunction

  function automatic logic [9:0] m_vec();
    logic [9:0] v;
    for (int c = 1; c <= 10; c++) v[c-1] = m_pend[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 1; c <= 10; c++) m_pend[c] = 1'b0;
    m_dir = 0; m_sol = 0; m_valid = 0; m_err = 0; m_pq = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int code, input bit ob,
                            input int p, input bit pu);
    bit np[1:10];
    bit above, below, serve_here;
    int nd, target;
    if (!e) begin
      m_pq = pu;
      return;
    end
    np = m_pend;
    if (v && code >= 1 && code <= 10) np[code] = 1'b1;
    above = 0; below = 0;
    for (int c = 1; c <= 10; c++)
      if (np[c]) begin
        if (floor_of(c) > p) above = 1;
        if (floor_of(c) < p) below = 1;
      end
    if (pu && !m_pq)
      for (int c = 1; c <= 10; c++)
        if (floor_of(c) == p) begin
          if (kind_of(c) == 0) np[c] = 0;
          else if (kind_of(c) == 1 && (m_dir != 2 || !below)) np[c] = 0;
          else if (kind_of(c) == 2 && (m_dir != 1 || !above)) np[c] = 0;
        end
    nd = m_dir;
    if (m_dir == 0) begin
      if (above && (!below || 1)) nd = 1;
      else if (below) nd = 2;
    end else if (m_dir == 1) begin
      if (!above) nd = below ? 2 : 0;
    end else begin
      if (!below) nd = above ? 1 : 0;
    end
    if (ob) begin
      serve_here = 0;
      for (int c = 1; c <= 10; c++)
        if (np[c] && floor_of(c) == p && (kind_of(c) == 0 || nd == 0 || kind_of(c) == nd))
          serve_here = 1;
      target = 0;
      if (serve_here) target = p + 1;
      else if (nd == 1) begin
        target = 99;
        for (int c = 1; c <= 10; c++)
          if (np[c] && floor_of(c) > p && floor_of(c) + 1 < target) target = floor_of(c) + 1;
      end else if (nd == 2) begin
        for (int c = 1; c <= 10; c++)
          if (np[c] && floor_of(c) < p && floor_of(c) + 1 > target) target = floor_of(c) + 1;
      end
      m_sol = target;
    end
    m_valid = ob;
    m_err   = v && code >= 11;
    m_pend  = np;
    m_dir   = nd;
    m_pq    = pu;
  endtask

  task automatic cycle(input bit e, input bit v, input int code, input bit ob,
                       input int p, input bit pu);
    en = e; boton_valid = v; boton_pres = 4'(code); obtener = ob; piso = 2'(p); puertas = pu;
    model_step(e, v, code, ob, p, pu);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pend"},  pendientes,      m_vec());
    check({tag, " dir"},   direccion,       m_dir);
    check({tag, " sol"},   solicitud,       m_sol);
    check({tag, " valid"}, solicitud_valid, m_valid);
    check({tag, " err"},   error_codigo,    m_err);
  endtask

  typedef struct {
    bit e, v; int code; bit ob; int p; bit pu;
    int pend, dir, sol; bit val, err;
  } vec_t;
  vec_t tbl[26];

  initial begin
    tbl[0]  = '{1,1,3,0,0,0, 'h004,1,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0, 'h004,1,0,0,0};
    tbl[2]  = '{1,0,0,1,0,0, 'h004,1,3,1,0};
    tbl[3]  = '{1,0,0,0,0,0, 'h004,1,3,0,0};
    tbl[4]  = '{1,0,0,0,2,1, 'h000,0,3,0,0};
    tbl[5]  = '{1,1,4,0,2,1, 'h008,1,3,0,0};
    tbl[6]  = '{1,1,6,0,1,0, 'h028,1,3,0,0};
    tbl[7]  = '{1,0,0,1,1,0, 'h028,1,4,1,0};
    tbl[8]  = '{1,0,0,0,3,1, 'h020,2,4,0,0};
    tbl[9]  = '{1,0,0,1,3,1, 'h020,2,2,1,0};
    tbl[10] = '{1,0,0,0,1,0, 'h020,0,2,0,0};
    tbl[11] = '{1,0,0,0,1,1, 'h000,0,2,0,0};
    tbl[12] = '{1,1,9,0,2,0, 'h100,0,2,0,0};
    tbl[13] = '{1,1,8,0,2,0, 'h180,0,2,0,0};
    tbl[14] = '{1,1,3,0,2,0, 'h184,0,2,0,0};
    tbl[15] = '{1,1,4,0,2,0, 'h18C,1,2,0,0};
    tbl[16] = '{1,0,0,0,2,1, 'h088,1,2,0,0};
    tbl[17] = '{1,0,0,0,3,0, 'h088,2,2,0,0};
    tbl[18] = '{1,0,0,0,3,1, 'h080,2,2,0,0};
    tbl[19] = '{1,0,0,0,2,0, 'h080,0,2,0,0};
    tbl[20] = '{1,0,0,1,2,1, 'h000,0,0,1,0};
    tbl[21] = '{1,1,12,0,2,1,'h000,0,0,0,1};
    tbl[22] = '{1,1,0,0,2,1, 'h000,0,0,0,0};
    tbl[23] = '{0,1,2,1,1,0, 'h000,0,0,0,0};
    tbl[24] = '{1,1,4,0,1,0, 'h008,1,0,0,0};
    tbl[25] = '{1,1,2,1,1,1, 'h008,1,4,1,0};

    rst = 1'b0; en = 0; boton_valid = 0; boton_pres = 0; obtener = 0; piso = 0; puertas = 0;
    model_reset();
    #2;
    check("reset pend",  pendientes, 0);
    check("reset dir",   direccion, 0);
    check("reset sol",   solicitud, 0);
    check("reset valid", solicitud_valid, 0);
    check("reset err",   error_codigo, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].e, tbl[i].v, tbl[i].code, tbl[i].ob, tbl[i].p, tbl[i].pu);
      check($sformatf("vec%0d pend", i),  pendientes,      tbl[i].pend);
      check($sformatf("vec%0d dir", i),   direccion,       tbl[i].dir);
      check($sformatf("vec%0d sol", i),   solicitud,       tbl[i].sol);
      check($sformatf("vec%0d valid", i), solicitud_valid, tbl[i].val);
      check($sformatf("vec%0d err", i),   error_codigo,    tbl[i].err);
    end

    // Five requests pending mid-sweep, then an asynchronous reset between edges.
    cycle(1,1,1,0,1,1);
    cycle(1,1,5,0,1,1);
    cycle(1,1,8,0,1,1);
    cycle(1,1,10,0,1,1);
    check("pre-reset pend", pendientes, 10'h299);
    check_model("pre-reset");
    puertas = 0; en = 0;
    #3 rst = 1'b0;
    #1;
    check("async pend",  pendientes, 0);
    check("async dir",   direccion, 0);
    check("async sol",   solicitud, 0);
    check("async valid", solicitud_valid, 0);
    check("async err",   error_codigo, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    begin
      int p;
      p = 0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 4) == 0) p = $urandom_range(0, 3);
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4, $urandom_range(0, 15),
              $urandom_range(0, 9) < 3, p, $urandom_range(0, 9) < 3);
        check_model($sformatf("rand%0d", n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
